pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
- Parametrised, pipelined carry-chain adder/subtractor: WIDTH-bit operands split into SLICE-bit slices, one slice added per pipeline stage, carry registered between stages.
- Successor to the fixed 32-bit two-slice ripple adder; the split adds throughput of one operation per clock at high WIDTH, plus add/sub mode and valid/ready flow control.
- Sits between operand-producing datapath logic and any downstream consumer that can apply backpressure.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of SLICE.
- SLICE, 8, bits added per stage; STAGES = WIDTH/SLICE (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) / NOT borrow (sub).

Behaviour:
- Reset, sampled on clk only: all stage-valid bits clear; out_valid=0, sum=0, cout=0. Reset during operation discards every in-flight beat with no output. in_ready=1 in the first cycle after reset if out_ready is don't-care.
- Operand conditioning at accept: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1) adds slice k of a and b_eff plus the carry from stage k-1 (c0 for k=0). It registers the SLICE-bit result and the carry-out.
- Untouched upper slices of a/b_eff are carried forward in skew registers. Completed lower sum slices are carried forward in deskew registers. All slices of one beat emerge together.
- Output: sum = concatenation of all slice results. cout = carry out of the last slice, so in sub mode cout=1 means no borrow.
- Latency: STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stall.
- Throughput: one beat per cycle.
- Flow control uses a global stall: adv = ~out_valid | out_ready, and in_ready = adv.
  - When adv=0, every pipeline register, including sum/cout/out_valid, holds its value.
  - When adv=1, all stages shift. Stage 0 valid loads in_valid & in_ready.
  - Bubbles propagate as valid=0 entries; their data is don't-care but must not be presented with out_valid=1.
- out_valid/sum/cout stay stable while out_valid=1 and out_ready=0.
- Simultaneous output handshake and input accept in one cycle is legal. The pipeline shifts by one and no beat is lost or duplicated.
- Wrap-around: sum is modulo 2^WIDTH, and the overflowed bit appears only on cout.
- STAGES=1 degenerates to a single registered adder with the same handshake.

Optional Feature:
- Macro PIPE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), resetting to 0 and held with sum. It is signed two's-complement overflow of the full WIDTH operation: carry into the MSB XOR carry out of the MSB, computed in the last stage and valid when out_valid=1.
- Undefined: no ovf port and no associated logic; all other behaviour is identical.

Test Plan (WIDTH=32, SLICE=8, so latency is 4):
- Add with carry: reset 2 cycles, then a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000_0100, cout=0. This checks carry rippling across a slice boundary.
- Full-width wrap: a=0xFFFF_FFFF, b=0x0000_0001, cin=0, add -> sum=0x0000_0000, cout=1. If PIPE_ADDER_OVF_EN is defined, ovf=0. Separately, a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0 (borrow). Then a=7, b=5, sub=1, cin=1 -> sum=1, cout=1.
- Streaming: 100 back-to-back random beats, in_valid=1 and out_ready=1 -> results in order, one per cycle from cycle 4, each matching a reference of a±b±cin mod 2^32.
- Backpressure: stream random beats while out_ready toggles randomly -> no loss, duplication or reorder. sum/cout are stable while out_valid & ~out_ready, and in_ready == (~out_valid | out_ready).
- Reset mid-flight: accept 3 beats, assert reset 1 cycle -> out_valid stays 0 for the following 4 cycles, and the first post-reset beat returns after exactly 4 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor split into SLICE-bit stages,
// one slice per stage with the carry registered between stages.
// Global-stall valid/ready flow control; latency STAGES cycles.
// Optional macro PIPE_ADDER_OVF_EN adds the signed-overflow output ovf.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / SLICE;

    // Per-stage state: valid bit, skewed operands (upper slices still to be
    // added), deskewed partial sum (lower slices already done) and carry.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              c_q [STAGES];
    logic              c_d [STAGES];
    logic              adv;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;
`endif

    // A single stall signal freezes every stage at once when the output is held.
    assign adv      = ~vld_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    // Next-state for every stage: add one slice on top of the previous stage.
    always_comb begin
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic [WIDTH-1:0] sv;
        logic             cv;
        logic             vv;
        logic [SLICE:0]   t;
        vld_d = '0;
`ifdef PIPE_ADDER_OVF_EN
        ovf_d = 1'b0;
`endif
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction as a + ~b + ~cin, conditioned once at accept.
                av = a;
                bv = sub ? ~b : b;
                cv = sub ? ~cin : cin;
                sv = '0;
                vv = in_valid & in_ready;
            end else begin
                av = a_q[k-1];
                bv = b_q[k-1];
                cv = c_q[k-1];
                sv = s_q[k-1];
                vv = vld_q[k-1];
            end
            t = {1'b0, av[k*SLICE +: SLICE]} + {1'b0, bv[k*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, cv};
            sv[k*SLICE +: SLICE] = t[SLICE-1:0];
            a_d[k]   = av;
            b_d[k]   = bv;
            s_d[k]   = sv;
            c_d[k]   = t[SLICE];
            vld_d[k] = vv;
`ifdef PIPE_ADDER_OVF_EN
            // Carry into the MSB is a^b^s at that bit; XOR with carry out.
            if (k == STAGES - 1)
                ovf_d = av[WIDTH-1] ^ bv[WIDTH-1] ^ t[SLICE-1] ^ t[SLICE];
`endif
        end
    end

    // Pipeline registers: cleared on reset, shifted together when adv is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            vld_q <= vld_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
`ifdef PIPE_ADDER_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
